// File: rtl/rx_frame_isolation_pkg.sv
// rx_frame_isolation_pkg: shared state enum, counter width and data-width legality check
package rx_frame_isolation_pkg;
  typedef enum logic [1:0] {IDLE, STORE, DROP} wr_state_t;
  localparam int CNT_W = 32;
  function automatic bit data_w_ok(input int w);
    return w == 64 || w == 128 || w == 256 || w == 512;
  endfunction
endpackage

// File: rtl/sdp_ram_reg.sv
// sdp_ram_reg: simple dual-port RAM with one write port and a registered read port
module sdp_ram_reg #(
  parameter int W = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  // write and registered read; contents are deliberately never reset
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/rx_frame_isolation.sv
// rx_frame_isolation: store-and-forward RX buffer that only releases fully received good frames
module rx_frame_isolation
  import rx_frame_isolation_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH = 512,
  parameter bit DROP_ON_ERR = 1'b1
) (
  input  logic                aclk,
  input  logic                aresetn,
  input  logic [DATA_W-1:0]   s_axis_tdata,
  input  logic [DATA_W/8-1:0] s_axis_tkeep,
  input  logic                s_axis_tvalid,
  input  logic                s_axis_tlast,
  input  logic                s_axis_tuser,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                m_axis_tvalid,
  output logic                m_axis_tlast,
  input  logic                m_axis_tready,
  output logic                rx_fifo_overflow,
  output logic [CNT_W-1:0]    good_frames,
  output logic [CNT_W-1:0]    dropped_frames
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int KW = DATA_W / 8;
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [KW-1:0]     keep;
    logic              last;
  } beat_t;

  if (!data_w_ok(DATA_W) || DEPTH < 16 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
    $error("rx_frame_isolation: illegal DATA_W or DEPTH");
  end

  wr_state_t     state, state_n;
  logic [PW-1:0] wr_ptr, wr_n, commit_ptr, commit_n, rd_ptr, fetch_ptr, commit_seen;
  logic          we, good_inc, drop_inc, ovf_n, has_space;
  logic          re, ram_vld, pop;
  logic [1:0]    cnt, kept;
  logic [2:0]    occ;
  beat_t         ram_q, q0, q1;

  // rd_ptr retires words only when the consumer accepts them, so prefetched words still count as used
  assign has_space = (wr_ptr - rd_ptr) != PW'(DEPTH);

  // write FSM: store beats, then commit, rewind on a bad frame, or rewind and discard on overflow
  always_comb begin
    state_n  = state;
    wr_n     = wr_ptr;
    commit_n = commit_ptr;
    we       = 1'b0;
    good_inc = 1'b0;
    drop_inc = 1'b0;
    ovf_n    = 1'b0;
    if (s_axis_tvalid) begin
      if (state == DROP) begin
        state_n = s_axis_tlast ? IDLE : DROP;
      end else if (!has_space) begin
        wr_n     = commit_ptr;
        ovf_n    = 1'b1;
        drop_inc = 1'b1;
        state_n  = s_axis_tlast ? IDLE : DROP;
      end else begin
        we      = 1'b1;
        wr_n    = wr_ptr + PW'(1);
        state_n = s_axis_tlast ? IDLE : STORE;
        if (s_axis_tlast && (s_axis_tuser || !DROP_ON_ERR)) begin
          commit_n = wr_ptr + PW'(1);
          good_inc = 1'b1;
        end else if (s_axis_tlast) begin
          wr_n     = commit_ptr;
          drop_inc = 1'b1;
        end
      end
    end
  end

  // write-side state, pointers, counters and the registered overflow pulse
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state            <= IDLE;
      wr_ptr           <= '0;
      commit_ptr       <= '0;
      rx_fifo_overflow <= 1'b0;
      good_frames      <= '0;
      dropped_frames   <= '0;
    end else begin
      state            <= state_n;
      wr_ptr           <= wr_n;
      commit_ptr       <= commit_n;
      rx_fifo_overflow <= ovf_n;
      good_frames      <= good_frames + CNT_W'(good_inc);
      dropped_frames   <= dropped_frames + CNT_W'(drop_inc);
    end
  end

  sdp_ram_reg #(.W($bits(beat_t)), .DEPTH(DEPTH)) u_ram (
    .clk  (aclk),
    .we   (we),
    .waddr(wr_ptr[AW-1:0]),
    .wdata({s_axis_tdata, s_axis_tkeep, s_axis_tlast}),
    .re   (re),
    .raddr(fetch_ptr[AW-1:0]),
    .rdata(ram_q)
  );

  // occ is the output-stage fill once this cycle's RAM word lands and any pop leaves
  assign pop  = m_axis_tvalid && m_axis_tready;
  assign occ  = 3'(cnt) + 3'(ram_vld) - 3'(pop);
  assign kept = cnt - 2'(pop);
  assign re   = fetch_ptr != commit_seen && occ < 3'd2;

  // read side: commit pointer is re-registered to keep the write path off the read-issue logic
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      commit_seen <= '0;
      fetch_ptr   <= '0;
      rd_ptr      <= '0;
      ram_vld     <= 1'b0;
      cnt         <= '0;
    end else begin
      commit_seen <= commit_ptr;
      fetch_ptr   <= fetch_ptr + PW'(re);
      rd_ptr      <= rd_ptr + PW'(pop);
      ram_vld     <= re;
      cnt         <= occ[1:0];
    end
  end

  // two-entry output stage: q0 is the presented beat, q1 absorbs the word in flight during a stall
  always_ff @(posedge aclk) begin
    if (ram_vld && kept == 2'd0) q0 <= ram_q;
    else if (pop) q0 <= q1;
    if (ram_vld && kept == 2'd1) q1 <= ram_q;
  end

  assign m_axis_tvalid = cnt != 2'd0;
  assign m_axis_tdata  = q0.data;
  assign m_axis_tkeep  = q0.keep;
  assign m_axis_tlast  = q0.last;
endmodule

// File: tb/tb_rx_frame_isolation.sv
// tb_rx_frame_isolation: directed and randomized frames checked against a frame-level model
module tb_rx_frame_isolation;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int DEPTH = 16;
  typedef struct packed {
    logic [DW-1:0] d;
    logic [KW-1:0] k;
    logic          l;
  } beat_t;

  logic          aclk = 1'b0, aresetn = 1'b0;
  logic [DW-1:0] s_tdata = '0;
  logic [KW-1:0] s_tkeep = '0;
  logic          s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic          m_tvalid, m_tlast;
  logic          m_tready = 1'b0;
  logic          ovf;
  logic [31:0]   good, dropped;

  int    errors = 0, checks = 0;
  beat_t exp_q[$];
  beat_t held, e;
  bit    stall = 1'b0, have;
  int    exp_good = 0, exp_drop = 0, exp_ovf = 0, ovf_seen = 0;
  int    acc = 0, cyc = 0, first_acc = -1, last_acc = -1;
  int    rdy_mode = 0;

  rx_frame_isolation #(.DATA_W(DW), .DEPTH(DEPTH), .DROP_ON_ERR(1'b1)) dut (
    .aclk            (aclk),
    .aresetn         (aresetn),
    .s_axis_tdata    (s_tdata),
    .s_axis_tkeep    (s_tkeep),
    .s_axis_tvalid   (s_tvalid),
    .s_axis_tlast    (s_tlast),
    .s_axis_tuser    (s_tuser),
    .m_axis_tdata    (m_tdata),
    .m_axis_tkeep    (m_tkeep),
    .m_axis_tvalid   (m_tvalid),
    .m_axis_tlast    (m_tlast),
    .m_axis_tready   (m_tready),
    .rx_fifo_overflow(ovf),
    .good_frames     (good),
    .dropped_frames  (dropped)
  );

  always #5 aclk = ~aclk;

  always @(posedge aclk) cyc++;

  // ready driver: 0 = held low, 1 = held high, 2 = random
  always @(posedge aclk) begin
    #1;
    m_tready = rdy_mode == 2 ? ($urandom % 4) != 0 : rdy_mode == 1;
  end

  // output monitor: in-order beat comparison, hold-while-stalled, overflow pulse count
  always @(negedge aclk) begin
    if (!aresetn) begin
      stall = 1'b0;
    end else begin
      if (ovf) ovf_seen++;
      if (stall) begin
        checks++;
        assert (m_tvalid === 1'b1 && {m_tdata, m_tkeep, m_tlast} === held)
        else begin
          errors++;
          $error("FAIL hold: observed valid=%0b beat=%h expected valid=1 beat=%h", m_tvalid, {m_tdata, m_tkeep, m_tlast}, held);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        acc++;
        if (first_acc < 0) first_acc = cyc;
        last_acc = cyc;
        have = exp_q.size() > 0;
        e = '0;
        if (have) e = exp_q.pop_front();
        assert (have && {m_tdata, m_tkeep, m_tlast} === e)
        else begin
          errors++;
          $error("FAIL beat: observed %h expected %h (queued=%0b)", {m_tdata, m_tkeep, m_tlast}, e, have);
        end
      end
      stall = m_tvalid && !m_tready;
      held = {m_tdata, m_tkeep, m_tlast};
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic chk_cnt(input string tag);
    chk({tag, " good_frames"}, good, exp_good);
    chk({tag, " dropped_frames"}, dropped, exp_drop);
    chk({tag, " overflow pulses"}, ovf_seen, exp_ovf);
  endtask

  // space < 0 means the buffer cannot fill; otherwise it is the exact free word count
  task automatic send_frame(input int len, input bit user, input int space, output int ovf_beat);
    beat_t fr[$];
    ovf_beat = 0;
    for (int i = 0; i < len; i++) begin
      s_tdata  = {$urandom, $urandom};
      s_tlast  = i == len - 1;
      s_tkeep  = s_tlast ? KW'($urandom_range(1, 255)) : '1;
      s_tuser  = s_tlast ? user : 1'($urandom);
      s_tvalid = 1'b1;
      fr.push_back({s_tdata, s_tkeep, s_tlast});
      @(posedge aclk);
      #1;
      if (ovf && ovf_beat == 0) ovf_beat = i + 1;
    end
    if (space >= 0 && len > space) begin
      exp_drop++;
      exp_ovf++;
    end else if (!user) begin
      exp_drop++;
    end else begin
      exp_good++;
      foreach (fr[j]) exp_q.push_back(fr[j]);
    end
  endtask

  task automatic idle(input int n);
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
    repeat (n) begin
      @(posedge aclk);
      #1;
    end
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || m_tvalid) && n < 400) begin
      @(posedge aclk);
      #1;
      n++;
    end
    idle(6);
    chk({tag, " drained"}, exp_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int ob, t, a0;
    repeat (3) @(posedge aclk);
    #1;
    chk("reset tvalid", m_tvalid, 0);
    chk("reset good", good, 0);
    chk("reset dropped", dropped, 0);
    chk("reset overflow", ovf, 0);
    aresetn = 1'b1;
    rdy_mode = 1;
    idle(2);
    // 4-beat good frame, latency from tlast
    a0 = acc;
    send_frame(4, 1'b1, -1, ob);
    s_tvalid = 1'b0;
    s_tlast = 1'b0;
    t = 0;
    while (!m_tvalid && t < 10) begin
      @(posedge aclk);
      #1;
      t++;
    end
    chk("latency", t, 3);
    drain("good4");
    chk("good4 beats", acc - a0, 4);
    chk_cnt("good4");
    // bad frame dropped, following good frame intact
    a0 = acc;
    send_frame(3, 1'b0, -1, ob);
    send_frame(5, 1'b1, -1, ob);
    idle(0);
    drain("bad3");
    chk("bad3 beats", acc - a0, 5);
    chk_cnt("bad3");
    // exact-fit frame then an overflowing frame with ready low
    rdy_mode = 0;
    idle(3);
    a0 = acc;
    send_frame(16, 1'b1, 16, ob);
    chk("full no overflow", ob, 0);
    send_frame(2, 1'b1, 0, ob);
    chk("overflow beat", ob, 1);
    idle(5);
    chk("held back beats", acc - a0, 0);
    chk_cnt("full");
    rdy_mode = 1;
    drain("full");
    chk("full beats", acc - a0, 16);
    // 20-beat frame into empty buffer, then a 16-beat frame must still fit
    rdy_mode = 0;
    idle(3);
    a0 = acc;
    send_frame(20, 1'b1, 16, ob);
    chk("long overflow beat", ob, 17);
    idle(5);
    chk("long no output", acc - a0, 0);
    send_frame(16, 1'b1, 16, ob);
    chk("refill no overflow", ob, 0);
    idle(2);
    chk_cnt("long");
    rdy_mode = 1;
    drain("long");
    chk("long beats", acc - a0, 16);
    // 100 back-to-back single-beat frames
    idle(2);
    a0 = acc;
    first_acc = -1;
    for (int i = 0; i < 100; i++) send_frame(1, 1'b1, -1, ob);
    idle(0);
    drain("b2b");
    chk("b2b beats", acc - a0, 100);
    chk("b2b span", last_acc - first_acc, 99);
    chk_cnt("b2b");
    // random frames with random ready
    rdy_mode = 2;
    for (int i = 0; i < 15; i++) begin
      send_frame($urandom_range(1, 6), ($urandom % 4) != 0, -1, ob);
      idle($urandom_range(0, 2));
      drain("random");
    end
    rdy_mode = 1;
    idle(3);
    chk_cnt("random");
    // reset mid-frame with two committed frames queued
    rdy_mode = 0;
    idle(3);
    send_frame(2, 1'b1, -1, ob);
    send_frame(2, 1'b1, -1, ob);
    for (int i = 0; i < 2; i++) begin
      s_tdata = {$urandom, $urandom};
      s_tkeep = '1;
      s_tlast = 1'b0;
      s_tvalid = 1'b1;
      @(posedge aclk);
      #1;
    end
    idle(4);
    chk("queued tvalid", m_tvalid, 1);
    aresetn = 1'b0;
    #1;
    chk("async reset tvalid", m_tvalid, 0);
    chk("async reset good", good, 0);
    chk("async reset dropped", dropped, 0);
    exp_q.delete();
    exp_good = 0;
    exp_drop = 0;
    exp_ovf = 0;
    ovf_seen = 0;
    @(posedge aclk);
    #1;
    aresetn = 1'b1;
    rdy_mode = 1;
    idle(6);
    chk("no stale output", m_tvalid, 0);
    a0 = acc;
    send_frame(1, 1'b0, -1, ob);
    send_frame(3, 1'b1, -1, ob);
    idle(0);
    drain("post reset");
    chk("post reset beats", acc - a0, 3);
    chk_cnt("post reset");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rx_frame_isolation.md
RX_FRAME_ISOLATION -- requirements
Module: rx_frame_isolation

Interface
REQ-001 SHALL have parameter DATA_W, default 64, giving the data width in bits (64, 128, 256 or 512).
REQ-002 SHALL have parameter DEPTH, default 512, giving the buffer depth in words (power of two, at least 16).
REQ-003 SHALL have parameter DROP_ON_ERR, default 1: when 1, frames flagged bad are discarded; when 0, bad frames are forwarded.
REQ-004 SHALL have the ports below; one clock, reset asynchronous and active-low.
- aclk  in  1  sole clock
- aresetn  in  1  asynchronous active-low reset
- s_axis_tdata  in  DATA_W  MAC receive data; no backpressure
- s_axis_tkeep  in  DATA_W/8  byte enables
- s_axis_tvalid  in  1  beat valid
- s_axis_tlast  in  1  last beat of frame
- s_axis_tuser  in  1  sampled on the tlast beat; 1 = good frame
- m_axis_tdata  out  DATA_W  output data
- m_axis_tkeep  out  DATA_W/8  output byte enables
- m_axis_tvalid  out  1  output valid
- m_axis_tlast  out  1  output last beat
- m_axis_tready  in  1  downstream ready
- rx_fifo_overflow  out  1  one-cycle pulse per frame dropped for lack of space
- good_frames  out  32  count of committed frames, wraps modulo 2^32
- dropped_frames  out  32  count of discarded frames (overflow or error), wraps modulo 2^32

Function
REQ-005 SHALL store and forward: no beat of a frame appears on m_axis before that frame's tlast beat is accepted and the frame is committed.
REQ-006 SHALL keep three pointers of width log2(DEPTH)+1: wr_ptr, commit_ptr and rd_ptr; free space is DEPTH-(wr_ptr-rd_ptr), computed modulo 2^(log2(DEPTH)+1).
REQ-007 SHALL run a write FSM with states IDLE, STORE and DROP.
REQ-008 On an IDLE or STORE beat with free space greater than 0, the write FSM SHALL write the word and increment wr_ptr; a first beat moves IDLE to STORE.
REQ-009 On a tlast beat, the write FSM SHALL commit if tuser=1 or DROP_ON_ERR=0: commit_ptr takes wr_ptr+1, good_frames increments, and the state returns to IDLE.
REQ-010 On a tlast beat with tuser=0 and DROP_ON_ERR=1, the write FSM SHALL rewind wr_ptr to commit_ptr, increment dropped_frames and return to IDLE.
REQ-011 On a beat arriving with free space 0, the write FSM SHALL rewind wr_ptr to commit_ptr, pulse rx_fifo_overflow and increment dropped_frames; it SHALL enter DROP, or stay in IDLE if that beat has tlast.
REQ-012 In DROP, the write FSM SHALL discard beats until a tlast beat, then return to IDLE; no further counter changes or pulses occur for that frame.
REQ-013 A single-beat frame (tvalid and tlast together in IDLE) SHALL be handled as REQ-009/010 in the same cycle.
REQ-014 The read side SHALL treat words as readable while rd_ptr differs from commit_ptr.
REQ-015 The read side SHALL use a registered-read RAM feeding a two-entry output stage, sustaining one beat per cycle while m_axis_tready=1.
REQ-016 Latency: m_axis_tvalid SHALL rise exactly 3 cycles after the accepting edge of the tlast beat when the buffer was empty.
REQ-017 AXI-Stream rules: once m_axis_tvalid=1, m_axis_tdata, tkeep and tlast SHALL hold stable until accepted; tvalid SHALL never depend combinationally on tready.
REQ-018 A commit and a read in the same cycle SHALL both take effect; a frame needing exactly DEPTH words SHALL be stored (full is not overflow until the next beat).

Reset
REQ-019 While aresetn=0, all pointers, both counters and rx_fifo_overflow SHALL be 0, the FSM SHALL be IDLE, and m_axis_tvalid SHALL be 0.
REQ-020 Reset mid-frame SHALL discard all uncommitted and committed data.
REQ-021 After release, the first beat SHALL be treated as frame start even if it is mid-frame on the wire; a resulting bad frame is dropped per REQ-010.
REQ-022 RAM contents SHALL NOT be reset.

Structure
REQ-023 The shared network package SHALL hold the FSM state enum, the 32-bit counter width constant and the data-width legality check.
REQ-024 One sub-module, sdp_ram_reg, SHALL implement the simple dual-port RAM with registered read, parametrised by width and depth.

Verification
REQ-025 (DATA_W=64, DEPTH=16) A 4-beat good frame with ready held high SHALL appear as 4 beats with data and tkeep intact, tvalid rising 3 cycles after tlast, and good_frames reading 1.
REQ-026 A 3-beat frame with tuser=0 on tlast SHALL produce no output, dropped_frames=1, and a following good frame output intact.
REQ-027 With ready held low, 16-beat then 2-beat frames SHALL store the first (full, no overflow) and drop the second with one overflow pulse; after releasing ready, only the 16-beat frame is output.
REQ-028 With ready held low, a 20-beat frame into an empty buffer SHALL produce an overflow pulse on beat 17, no output, and wr_ptr equal to commit_ptr.
REQ-029 Back-to-back 1-beat frames every cycle for 100 cycles with ready=1 SHALL output 100 beats with no gaps after the first, and good_frames=100.
REQ-030 Asserting aresetn=0 mid-frame with 2 committed frames queued SHALL drop tvalid low immediately, zero both counters, and produce no stale data after release.
